// File: rtl/agc_phase_sequencer.sv
// AGC timer sequencer: divides CLK_EN ticks into phases, time pulses and memory cycles,
// with STOP halting, MCT/time-pulse single-stepping and a free-running P scaler.
module agc_phase_sequencer #(
  parameter int PHASES   = 4,
  parameter int NTP      = 12,
  parameter int RT_PH    = 1,
  parameter int WT_PH    = 2,
  parameter int CT_PH    = 3,
  parameter int NSCALER  = 5,
  parameter int PRESCALE = 48
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               CLK_EN,
  input  logic               STOP,
  input  logic               STEP,
  input  logic               STEP_TP,
  output logic [PHASES-1:0]  PHS,
  output logic [NTP-1:0]     T,
  output logic               RT,
  output logic               WT,
  output logic               CT,
  output logic               MCT,
  output logic               HALTED,
  output logic [NSCALER-1:0] P,
  output logic [NSCALER-1:0] P_
);

  localparam int PH_W = $clog2(PHASES);
  localparam int TP_W = $clog2(NTP);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_STEP
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [TP_W-1:0]    tp_q, tp_d;
  logic [PS_W-1:0]    pre_q, pre_d;
  logic [NSCALER-1:0] p_q, p_d;
  logic               mct_q, mct_d;
  logic               step_pend_q, step_pend_d;
  logic               step_prev_q, step_prev_d;

  logic step_edge;
  logic ph_last;
  logic tp_last;

  always_comb begin
    mode_d      = mode_q;
    ph_d        = ph_q;
    tp_d        = tp_q;
    pre_d       = pre_q;
    p_d         = p_q;
    mct_d       = 1'b0;
    step_prev_d = STEP;
    step_edge   = STEP & ~step_prev_q;
    ph_last     = (ph_q == PH_W'(PHASES - 1));
    tp_last     = (tp_q == TP_W'(NTP - 1));
    step_pend_d = step_pend_q | (step_edge & (mode_q == ST_HALT));

    if (CLK_EN) begin
      if (pre_q == PS_W'(PRESCALE - 1)) begin
        pre_d = '0;
        p_d   = p_q + NSCALER'(1);
      end else begin
        pre_d = pre_q + PS_W'(1);
      end

      case (mode_q)
        ST_HALT: begin
          // Leaving halt always starts from ph=0, so this tick can never be a boundary.
          if (step_pend_q || !STOP) begin
            mode_d      = step_pend_q ? ST_STEP : ST_RUN;
            step_pend_d = 1'b0;
            ph_d        = ph_q + PH_W'(1);
          end
        end
        default: begin
          if (ph_last) begin
            ph_d  = '0;
            tp_d  = tp_last ? '0 : tp_q + TP_W'(1);
            mct_d = tp_last;
            if (STEP_TP || tp_last) begin
              mode_d = STOP ? ST_HALT : ST_RUN;
            end
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      mode_q      <= ST_RUN;
      ph_q        <= '0;
      tp_q        <= '0;
      pre_q       <= '0;
      p_q         <= '0;
      mct_q       <= 1'b0;
      step_pend_q <= 1'b0;
      step_prev_q <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      ph_q        <= ph_d;
      tp_q        <= tp_d;
      pre_q       <= pre_d;
      p_q         <= p_d;
      mct_q       <= mct_d;
      step_pend_q <= step_pend_d;
      step_prev_q <= step_prev_d;
    end
  end

  always_comb begin
    PHS = '0;
    T   = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      PHS[i] = (ph_q == PH_W'(i));
    end
    for (int unsigned j = 0; j < NTP; j++) begin
      T[j] = (tp_q == TP_W'(j));
    end
  end

  assign HALTED = (mode_q == ST_HALT);
  assign RT     = (ph_q == PH_W'(RT_PH)) & ~HALTED;
  assign WT     = (ph_q == PH_W'(WT_PH)) & ~HALTED;
  assign CT     = (ph_q == PH_W'(CT_PH)) & ~HALTED;
  assign MCT    = mct_q;
  assign P      = p_q;
  assign P_     = ~p_q;

endmodule

// File: tb/tb_agc_phase_sequencer.sv
// Scoreboard bench for agc_phase_sequencer: a reference model queues the expected outputs
// for every cycle, plus directed checks of halting, stepping, scaler wrap and reset.
module tb_agc_phase_sequencer;

  localparam int PHASES   = 4;
  localparam int NTP      = 12;
  localparam int NSCALER  = 5;
  localparam int PRESCALE = 48;

  logic               clk = 1'b0;
  logic               rst, clk_en, stop, step, step_tp;
  logic [PHASES-1:0]  phs;
  logic [NTP-1:0]     t;
  logic               rt, wt, ct, mct, halted;
  logic [NSCALER-1:0] p, p_n;

  agc_phase_sequencer #(
    .PHASES  (PHASES),
    .NTP     (NTP),
    .RT_PH   (1),
    .WT_PH   (2),
    .CT_PH   (3),
    .NSCALER (NSCALER),
    .PRESCALE(PRESCALE)
  ) dut (
    .SIM_CLK(clk),
    .SIM_RST(rst),
    .CLK_EN (clk_en),
    .STOP   (stop),
    .STEP   (step),
    .STEP_TP(step_tp),
    .PHS    (phs),
    .T      (t),
    .RT     (rt),
    .WT     (wt),
    .CT     (ct),
    .MCT    (mct),
    .HALTED (halted),
    .P      (p),
    .P_     (p_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef logic [30:0] obs_t;
  obs_t sb_q[$];

  int m_ph, m_tp, m_pre, m_p;
  bit m_halt, m_pend, m_prev, m_mct;
  int mct_seen;

  task automatic model_reset();
    m_ph = 0; m_tp = 0; m_pre = 0; m_p = 0;
    m_halt = 0; m_pend = 0; m_prev = 1; m_mct = 0;
  endtask

  task automatic model_clock();
    bit edge_s, pend_n;
    edge_s = step && !m_prev;
    pend_n = m_pend | (edge_s & m_halt);
    m_mct  = 0;
    if (clk_en) begin
      m_pre++;
      if (m_pre == PRESCALE) begin
        m_pre = 0;
        m_p   = (m_p + 1) % (1 << NSCALER);
      end
      if (m_halt) begin
        if (m_pend || !stop) begin
          m_halt = 0;
          pend_n = 0;
          m_ph   = 1;
        end
      end else begin
        m_ph++;
        if (m_ph == PHASES) begin
          m_ph = 0;
          m_tp++;
          if (m_tp == NTP) begin
            m_tp  = 0;
            m_mct = 1;
          end
          if (step_tp || m_mct) m_halt = stop;
        end
      end
    end
    m_pend = pend_n;
    m_prev = step;
  endtask

  function automatic obs_t model_obs();
    logic [PHASES-1:0]  e_phs;
    logic [NTP-1:0]     e_t;
    logic [NSCALER-1:0] e_p;
    e_phs = 4'b0001 << m_ph;
    e_t   = 12'd1 << m_tp;
    e_p   = 5'(m_p);
    return {e_phs, e_t, (m_ph == 1) && !m_halt, (m_ph == 2) && !m_halt,
            (m_ph == 3) && !m_halt, m_mct, m_halt, e_p, ~e_p};
  endfunction

  function automatic obs_t dut_obs();
    return {phs, t, rt, wt, ct, mct, halted, p, p_n};
  endfunction

  task automatic cyc();
    if (rst) model_reset();
    else     model_clock();
    sb_q.push_back(model_obs());
    @(posedge clk);
    @(negedge clk);
    check_eq("sb", 64'(dut_obs()), 64'(sb_q.pop_front()));
    if (mct) mct_seen++;
  endtask

  task automatic tick();
    clk_en = 1'b1;
    cyc();
    clk_en = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
  endtask

  task automatic run_until_halt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!halted && n < 300);
    check_eq("halt_timeout", 64'(halted), 64'd1);
  endtask

  initial begin
    int n;
    logic [NSCALER-1:0] pb;
    rst = 1'b1; clk_en = 1'b0; stop = 1'b0; step = 1'b0; step_tp = 1'b0;
    mct_seen = 0;
    model_reset();
    #1;
    check_eq("rst_phs", 64'(phs), 64'd1);
    check_eq("rst_t", 64'(t), 64'd1);
    check_eq("rst_pn", 64'(p_n), 64'd31);
    check_eq("rst_strobes", 64'({rt, wt, ct, mct, halted}), 64'd0);
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;

    // Free run and scaler wrap
    repeat (PRESCALE * 31) tick();
    check_eq("p31", 64'(p), 64'd31);
    check_eq("pn0", 64'(p_n), 64'd0);
    check_eq("mct_count", 64'(mct_seen), 64'd31);
    repeat (PRESCALE) tick();
    check_eq("p_wrap", 64'(p), 64'd0);
    check_eq("pn_wrap", 64'(p_n), 64'd31);

    // Halt at end of MCT
    n = 0;
    while (t !== 12'd16 && n < 100) begin
      tick();
      n++;
    end
    check_eq("reach_t16", 64'(t), 64'd16);
    stop = 1'b1;
    run_until_halt(n);
    check_eq("halt_t", 64'(t), 64'd1);
    check_eq("halt_phs", 64'(phs), 64'd1);
    check_eq("halt_strobes", 64'({rt, wt, ct}), 64'd0);
    pb = p;
    repeat (PRESCALE) tick();
    check_eq("p_while_halted", 64'(p), 64'(5'(pb + 5'd1)));
    check_eq("still_halted", 64'(halted), 64'd1);

    // Single step by MCT, then by time pulse
    pulse_step();
    mct_seen = 0;
    run_until_halt(n);
    check_eq("step_mct_ticks", 64'(n), 64'd48);
    check_eq("step_mct_count", 64'(mct_seen), 64'd1);
    check_eq("step_mct_t", 64'(t), 64'd1);
    step_tp = 1'b1;
    pulse_step();
    run_until_halt(n);
    check_eq("step_tp_ticks", 64'(n), 64'd4);
    check_eq("step_tp_t", 64'(t), 64'd2);

    // Resume by dropping STOP; step while running is ignored
    stop = 1'b0;
    tick();
    check_eq("resume_halted", 64'(halted), 64'd0);
    check_eq("resume_phs", 64'(phs), 64'd2);
    step_tp = 1'b0;
    repeat (5) tick();
    pulse_step();
    repeat (60) tick();
    check_eq("run_after_step", 64'(halted), 64'd0);

    // Asynchronous reset mid-MCT with STEP held across release
    repeat (7) tick();
    step = 1'b1;
    rst  = 1'b1;
    #1;
    check_eq("arst_phs", 64'(phs), 64'd1);
    check_eq("arst_t", 64'(t), 64'd1);
    check_eq("arst_pn", 64'(p_n), 64'd31);
    check_eq("arst_flags", 64'({mct, halted}), 64'd0);
    cyc();
    rst  = 1'b0;
    stop = 1'b1;
    run_until_halt(n);
    check_eq("rst_halt_ticks", 64'(n), 64'd48);
    repeat (8) tick();
    check_eq("no_step_halted", 64'(halted), 64'd1);
    check_eq("no_step_t", 64'(t), 64'd1);
    step = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
